// File: rtl/quant_pkg.sv
// Shared quantisation types and saturation bounds for the MAC accumulator and requant stages.
package quant_pkg;
  localparam int DATA_W_DEF = 8;
  localparam int ACC_W_DEF  = 32;

  typedef logic signed [DATA_W_DEF-1:0] data_t;
  typedef logic signed [ACC_W_DEF-1:0]  acc_t;

  function automatic longint acc_max(input int w);
    return (longint'(1) <<< (w - 1)) - 1;
  endfunction

  function automatic longint acc_min(input int w);
    return -(longint'(1) <<< (w - 1));
  endfunction
endpackage

// File: rtl/mac_acc_stream_sat_add.sv
// Combinational W-bit signed adder with optional saturation and an overflow flag.
module sat_add
  import quant_pkg::*;
#(
  parameter int W = ACC_W_DEF
) (
  input  logic signed [W-1:0] a,
  input  logic signed [W-1:0] b,
  input  logic                sat_en,
  output logic signed [W-1:0] sum,
  output logic                ovf
);
  logic signed [W:0] full;

  assign full = (W+1)'(a) + (W+1)'(b);
  assign ovf  = full[W] ^ full[W-1];

  always_comb begin
    sum = full[W-1:0];
    if (sat_en && ovf) sum = full[W] ? W'(acc_min(W)) : W'(acc_max(W));
  end
endmodule

// File: rtl/mac_acc_stream.sv
// Zero-point corrected int8 MAC accumulating cfg_len products per group into a decoupled output register.
// Define MAC_ACC_SAT_EN for saturating accumulation with a sticky per-group acc_ovf output.
module mac_acc_stream
  import quant_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ACC_W  = ACC_W_DEF,
  parameter int LEN_W  = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic signed [DATA_W-1:0] in_act,
  input  logic signed [DATA_W-1:0] in_wgt,
  input  logic signed [DATA_W-1:0] act_zp,
  input  logic        [LEN_W-1:0]  cfg_len,
  input  logic                     clear,
  output logic                     acc_valid,
  input  logic                     acc_ready,
`ifdef MAC_ACC_SAT_EN
  output logic                     acc_ovf,
`endif
  output logic signed [ACC_W-1:0]  acc_data
);
  localparam int PROD_W = 2*DATA_W + 1;
`ifdef MAC_ACC_SAT_EN
  localparam bit SAT_EN = 1'b1;
`else
  localparam bit SAT_EN = 1'b0;
`endif

  logic [LEN_W-1:0]         cnt, len_q, len_eff;
  logic signed [DATA_W:0]   diff;
  logic signed [PROD_W-1:0] prod;
  logic signed [ACC_W-1:0]  acc, add_a, prod_ext, sum;
  logic                     first, last, fire, add_ovf;

  assign first = (cnt == '0);

  // Length comes straight from cfg_len on a group's first beat, else from the latch.
  always_comb begin
    len_eff = len_q;
    if (first) len_eff = (cfg_len == '0) ? LEN_W'(1) : cfg_len;
  end

  assign last     = (cnt == len_eff - LEN_W'(1));
  assign in_ready = !clear && !(last && acc_valid && !acc_ready);
  assign fire     = in_valid && in_ready;

  assign diff     = (DATA_W+1)'(in_act) - (DATA_W+1)'(act_zp);
  assign prod     = PROD_W'(diff) * PROD_W'(in_wgt);
  assign prod_ext = ACC_W'(prod);
  assign add_a    = first ? '0 : acc;

  sat_add #(.W(ACC_W)) u_add (
    .a      (add_a),
    .b      (prod_ext),
    .sat_en (SAT_EN),
    .sum    (sum),
    .ovf    (add_ovf)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt       <= '0;
      len_q     <= LEN_W'(1);
      acc       <= '0;
      acc_valid <= 1'b0;
      acc_data  <= '0;
    end else begin
      // A final beat loading the register below overrides this drain.
      if (acc_valid && acc_ready) acc_valid <= 1'b0;
      if (clear) begin
        cnt <= '0;
        acc <= '0;
      end else if (fire) begin
        if (first) len_q <= len_eff;
        if (last) begin
          acc_data  <= sum;
          acc_valid <= 1'b1;
          cnt       <= '0;
          acc       <= '0;
        end else begin
          acc <= sum;
          cnt <= cnt + LEN_W'(1);
        end
      end
    end
  end

`ifdef MAC_ACC_SAT_EN
  logic grp_ovf;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      grp_ovf <= 1'b0;
      acc_ovf <= 1'b0;
    end else if (clear) begin
      grp_ovf <= 1'b0;
    end else if (fire) begin
      if (last) begin
        acc_ovf <= grp_ovf | add_ovf;
        grp_ovf <= 1'b0;
      end else begin
        grp_ovf <= grp_ovf | add_ovf;
      end
    end
  end
`else
  logic unused_ovf;
  assign unused_ovf = add_ovf;
`endif
endmodule

// File: tb/tb_mac_acc_stream.sv
// Directed bench for mac_acc_stream (ACC_W=16) with a per-cycle group-level model and literal checks.
// Build with MAC_ACC_SAT_EN defined to exercise the saturating variant.
module tb_mac_acc_stream;
  localparam int DW = 8;
  localparam int AW = 16;
  localparam int LW = 16;

  logic                 clk = 1'b0;
  logic                 rst_n, in_valid, in_ready, clear, acc_valid, acc_ready;
  logic signed [DW-1:0] in_act, in_wgt, act_zp;
  logic        [LW-1:0] cfg_len;
  logic signed [AW-1:0] acc_data;
`ifdef MAC_ACC_SAT_EN
  logic                 acc_ovf;
`endif

  mac_acc_stream #(.DATA_W(DW), .ACC_W(AW), .LEN_W(LW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_act    (in_act),
    .in_wgt    (in_wgt),
    .act_zp    (act_zp),
    .cfg_len   (cfg_len),
    .clear     (clear),
    .acc_valid (acc_valid),
    .acc_ready (acc_ready),
`ifdef MAC_ACC_SAT_EN
    .acc_ovf   (acc_ovf),
`endif
    .acc_data  (acc_data)
  );

  always #5 clk = ~clk;

  int nvec = 0;
  int nerr = 0;
  logic signed [AW-1:0] dq[$];

  task automatic chk(input string nm, input logic signed [63:0] got, input logic signed [63:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d", nm, got, exp);
    end
  endtask

  // Group-level model: true arithmetic, then wrap or clamp to AW bits per addition.
  bit     started = 0;
  int     m_terms, m_len;
  longint m_sum, m_data;
  bit     m_valid, m_ovf, m_dovf;

  function automatic longint fix(input longint v, output bit o);
    longint lo, hi, r;
    lo = -(longint'(1) << (AW - 1));
    hi = (longint'(1) << (AW - 1)) - 1;
    o  = (v < lo) || (v > hi);
`ifdef MAC_ACC_SAT_EN
    r = (v < lo) ? lo : (v > hi) ? hi : v;
`else
    r = v & ((longint'(1) << AW) - 1);
    if (r > hi) r -= (longint'(1) << AW);
`endif
    return r;
  endfunction

  function automatic int m_eff();
    return (m_terms == 0) ? ((cfg_len == 0) ? 1 : int'(cfg_len)) : m_len;
  endfunction

  function automatic bit m_rdy();
    return !clear && !((m_terms == m_eff() - 1) && m_valid && !acc_ready);
  endfunction

  always @(posedge clk) begin
    if (!rst_n) begin
      m_terms = 0; m_len = 1; m_sum = 0; m_data = 0;
      m_valid = 0; m_ovf = 0; m_dovf = 0;
      started = 1;
    end else if (started) begin
      bit     rdy, pop, loaded, o;
      int     eff;
      longint s;
      rdy    = m_rdy();
      eff    = m_eff();
      pop    = m_valid && acc_ready;
      loaded = 0;
      s = (m_terms == 0 ? 0 : m_sum) + longint'((int'(in_act) - int'(act_zp)) * int'(in_wgt));
      s = fix(s, o);
      if (clear) begin
        m_terms = 0; m_sum = 0; m_ovf = 0;
      end else if (in_valid && rdy) begin
        if (m_terms == 0) m_len = eff;
        if (m_terms == eff - 1) begin
          m_data = s; m_dovf = m_ovf | o; m_valid = 1; loaded = 1;
          m_terms = 0; m_sum = 0; m_ovf = 0;
        end else begin
          m_sum = s; m_ovf = m_ovf | o; m_terms++;
        end
      end
      if (pop && !loaded) m_valid = 0;
    end
  end

  // Compare every cycle, well clear of both edges.
  always @(negedge clk) begin
    #2;
    if (started && rst_n) begin
      chk("in_ready", in_ready, m_rdy());
      chk("acc_valid", acc_valid, m_valid);
      chk("acc_data", acc_data, m_data);
`ifdef MAC_ACC_SAT_EN
      if (m_valid) chk("acc_ovf", acc_ovf, m_dovf);
`endif
      if (acc_valid && acc_ready) dq.push_back(acc_data);
    end
  end

  task automatic beat(input int a, input int w, input int z, input int l);
    bit ok;
    @(negedge clk);
    in_valid = 1; in_act = DW'(a); in_wgt = DW'(w); act_zp = DW'(z); cfg_len = LW'(l);
    for (int i = 0; i < 50; i++) begin
      #1 ok = in_ready;
      @(posedge clk);
      if (ok) return;
      @(negedge clk);
    end
    nvec++; nerr++;
    $display("FAIL beat_timeout: got no accept expected accept within 50 cycles");
  endtask

  task automatic idle(input int n);
    @(negedge clk);
    in_valid = 0;
    repeat (n) @(negedge clk);
  endtask

  initial begin
    rst_n = 0; in_valid = 0; clear = 0; acc_ready = 1;
    in_act = 0; in_wgt = 0; act_zp = 0; cfg_len = 1;
    repeat (2) @(negedge clk);
    rst_n = 1;
    #2;
    chk("rst_valid", acc_valid, 0);
    chk("rst_data", acc_data, 0);
    chk("rst_ready", in_ready, 1);

    // basic: 1*4 + 2*5 + 3*6 = 32, visible the cycle after the last beat
    dq.delete();
    beat(1, 4, 0, 3); beat(2, 5, 0, 3); beat(3, 6, 0, 3);
    #2;
    chk("basic_valid", acc_valid, 1);
    chk("basic_data", acc_data, 32);
    idle(2);
    chk("basic_n", dq.size(), 1);
    if (dq.size() == 1) chk("basic_dq", dq[0], 32);

    // zero point: 4 * (10-3)*-2 = -56; (-128 - -128)*77 = 0
    dq.delete();
    repeat (4) beat(10, -2, 3, 4);
    #2 chk("zp_data", acc_data, -56);
    beat(-128, 77, -128, 1);
    #2 chk("zp_zero", acc_data, 0);
    idle(2);
    chk("zp_n", dq.size(), 2);
    if (dq.size() == 2) begin
      chk("zp_dq0", dq[0], -56);
      chk("zp_dq1", dq[1], 0);
    end

    // backpressure: 7 stalls, next group's final beat waits, 11 follows
    dq.delete();
    acc_ready = 0;
    beat(3, 1, 0, 2); beat(4, 1, 0, 2);
    beat(2, 5, 0, 2);
    @(negedge clk);
    in_valid = 1; in_act = 1; in_wgt = 1; act_zp = 0; cfg_len = 2;
    repeat (3) begin
      #1;
      chk("bp_stall_ready", in_ready, 0);
      chk("bp_hold_data", acc_data, 7);
      chk("bp_hold_valid", acc_valid, 1);
      @(negedge clk);
    end
    acc_ready = 1;
    #1 chk("bp_release_ready", in_ready, 1);
    @(posedge clk);
    #2;
    chk("bp_pass_valid", acc_valid, 1);
    chk("bp_pass_data", acc_data, 11);
    idle(2);
    chk("bp_n", dq.size(), 2);
    if (dq.size() == 2) begin
      chk("bp_dq0", dq[0], 7);
      chk("bp_dq1", dq[1], 11);
    end

    // overflow: 2 * 255 * -128 = -65280
    beat(127, -128, -128, 2); beat(127, -128, -128, 2);
    #2;
`ifdef MAC_ACC_SAT_EN
    chk("ovf_sat_data", acc_data, -32768);
    chk("ovf_flag", acc_ovf, 1);
`else
    chk("ovf_wrap_data", acc_data, 256);
`endif
    idle(1);

    // clear mid-group, then a len=1 group
    beat(1, 1, 0, 4); beat(1, 1, 0, 4);
    @(negedge clk);
    clear = 1; in_valid = 1; in_act = 9; in_wgt = 9;
    #1 chk("clr_ready", in_ready, 0);
    @(negedge clk);
    clear = 0; in_valid = 0;
    beat(5, 3, 0, 1);
    #2 chk("clr_next", acc_data, 15);
    idle(1);

    // reset mid-group with a stalled result pending
    acc_ready = 0;
    beat(9, 1, 0, 1);
    beat(1, 1, 0, 4); beat(1, 1, 0, 4);
    @(negedge clk);
    in_valid = 0; rst_n = 0;
    @(negedge clk);
    rst_n = 1;
    #2;
    chk("rst_mid_valid", acc_valid, 0);
    chk("rst_mid_data", acc_data, 0);
    acc_ready = 1;
    beat(5, 3, 0, 1);
    #2 chk("rst_next", acc_data, 15);
    idle(1);

    // cfg_len=0 acts as 1; mid-group cfg_len changes are ignored
    dq.delete();
    beat(2, 3, 0, 0);
    #2 chk("len0_data", acc_data, 6);
    beat(1, 1, 0, 3); beat(2, 1, 0, 1);
    #2 chk("lenchg_pending", acc_valid, 0);
    beat(3, 1, 0, 7);
    #2;
    chk("lenchg_valid", acc_valid, 1);
    chk("lenchg_data", acc_data, 6);
    beat(4, 4, 0, 1);
    #2 chk("lenchg_next", acc_data, 16);
    idle(2);
    chk("len_n", dq.size(), 3);
    if (dq.size() == 3) chk("len_dq2", dq[2], 16);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
